credit_link_arbiter: RTL
========================

// Module: credit_link_arbiter
// PURPOSE
//  Sender-side controller for one credit-based push link feeding a credit_receiver.
//  Shares the link between NUM_REQ requesters with round-robin arbitration.
//  Tracks sender-side credits and issues a push only when a credit is available.
//  Sequences the sender/receiver reset handshake, including the initial credit load.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_W      8   push payload width
//  CREDIT_MAX  8   maximum credits held; CW = $clog2(CREDIT_MAX+1)
// PORTS
//  clk                     in   1           clock
//  rst_n                   in   1           reset, asynchronous assert, active-low
//  req_valid               in   NUM_REQ     requester i has a word
//  req_data                in   NUM_REQ*DATA_W  payload; slice i belongs to requester i
//  req_ready               out  NUM_REQ     one-hot grant; word i is consumed this cycle
//  push_sender_in_reset    out  1           sender side in reset or sync
//  push_receiver_in_reset  in   1           receiver side in reset
//  push_valid              out  1           link data valid (registered)
//  push_data               out  DATA_W      link payload (registered)
//  push_credit             in   1           one credit returned this cycle
//  push_credit_stall       out  1           asks the receiver to hold credit returns
//  credit_initial          in   CW          credits loaded on entry to ACTIVE
//  credit_withhold         in   CW          credits kept in reserve; not spent
//  credit_count            out  CW          current credits held
//  credit_available        out  1           credit_count > credit_withhold
//  credit_overflow         out  1           sticky error flag
// BEHAVIOUR
//  Reset (rst_n=0): state=RESET, credit_count=0, push_valid=0, push_data=0, req_ready=0,
//   push_sender_in_reset=1, push_credit_stall=1, credit_overflow=0, rr pointer=0.
//  FSM (states in package):
//   RESET -> SYNC on the first clk after rst_n deasserts.
//   SYNC  -> ACTIVE when push_receiver_in_reset=0. On that edge, credit_count <= min(credit_initial, CREDIT_MAX).
//   ACTIVE -> SYNC when push_receiver_in_reset=1, in any cycle. On that edge, credit_count <= 0 and push_valid <= 0.
//    Any in-flight grant in that cycle is suppressed.
//  push_sender_in_reset=1 and push_credit_stall=1 in RESET/SYNC; both 0 in ACTIVE.
//  Grant (combinational, ACTIVE only): if credit_available and any req_valid, the rr_arbiter
//   picks the first valid requester at or after the pointer and asserts req_ready[i] one-hot.
//   The pointer then advances to i+1 mod NUM_REQ. With no grant, the pointer holds.
//  Latency: the grant cycle registers push_valid<=1 and push_data<=req_data[i]. Grant to link takes 1 cycle.
//   Without a grant, push_valid<=0 and push_data holds.
//  Credits (ACTIVE): next = count - grant + push_credit. A simultaneous grant and return leaves count unchanged.
//   A return with count==CREDIT_MAX and no grant leaves count at CREDIT_MAX and sets credit_overflow. The flag clears only on rst_n.
//   push_credit is ignored outside ACTIVE.
//  No grant when count <= credit_withhold. A withhold >= count freezes the link and keeps pending requests pending.
//  Throughput: 1 word/cycle while credits allow. At most one push per cycle.
// STRUCTURE
//  credit_link_pkg: typedef enum {RESET,SYNC,ACTIVE} link_state_e; credit width function.
//  Sub-module rr_arbiter #(NUM_REQ): req vector + pointer -> one-hot grant + next pointer.
//  The top level holds the FSM, credit counter, output registers and overflow flag.
// TESTING
//  T1 reset/sync: hold receiver_in_reset=1 for 5 cycles after rst_n rises -> stays in SYNC;
//   sender_in_reset=1, no grants. Release with credit_initial=3 -> credit_count=3 next cycle.
//  T2 round robin: credits=8, all 4 requesters valid -> grants 0,1,2,3,0 on successive cycles;
//   push_data matches each, 1 cycle later.
//  T3 exhaustion: credit_initial=2, one requester always valid, no returns -> exactly 2 pushes,
//   then req_ready=0 and count=0. One push_credit pulse -> exactly one more push.
//  T4 simultaneous: count=1, grant and push_credit in the same cycle -> count stays 1.
//   Withhold=1 with count=1 -> no grant.
//  T5 overflow: count=CREDIT_MAX=8, idle, push_credit=1 -> count=8, credit_overflow=1, sticky.
//  T6 mid-run receiver reset: receiver_in_reset pulses during streaming -> push_valid=0 next cycle, count=0.
//   After release -> resume with credit_initial; no duplicated or lost accepted word.

Source files
------------

// File: rtl/credit_link_arbiter_pkg.sv
// Shared types and helpers for the credit-based push link sender.
package credit_link_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } link_state_e;

  // Bits needed to hold a credit count of 0..max_credits inclusive.
  function automatic int credit_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/credit_link_arbiter_if.sv
// Requester-side handshake and push-link signals of the credit link arbiter.
interface credit_link_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      push_sender_in_reset;
  logic                      push_receiver_in_reset;
  logic                      push_valid;
  logic [DATA_W-1:0]         push_data;
  logic                      push_credit;
  logic                      push_credit_stall;

  modport master (
    input  req_valid, req_data, push_receiver_in_reset, push_credit,
    output req_ready, push_sender_in_reset, push_valid, push_data, push_credit_stall
  );

  modport slave (
    output req_valid, req_data, push_receiver_in_reset, push_credit,
    input  req_ready, push_sender_in_reset, push_valid, push_data, push_credit_stall
  );
endinterface

// File: rtl/credit_link_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after the pointer wins;
// the pointer moves just past the winner, or holds when nothing is granted.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_any_o,
  output logic [PW-1:0]      gnt_idx_o,
  output logic [PW-1:0]      ptr_next_o
);

  int   pos;
  logic found;

  // Rotating priority scan starting at the pointer.
  always_comb begin
    gnt_o      = '0;
    gnt_idx_o  = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        gnt_idx_o  = PW'(pos);
      end else begin
        found = found;
      end
    end
    if (found) begin
      ptr_next_o = (int'(gnt_idx_o) == NUM_REQ - 1) ? '0 : PW'(int'(gnt_idx_o) + 1);
    end else begin
      ptr_next_o = ptr_i;
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/credit_link_arbiter.sv
// Sender-side controller for a credit-based push link: reset handshake with the
// receiver, credit accounting, and round-robin sharing of the link.
module credit_link_arbiter
  import credit_link_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_W     = 8,
  parameter  int CREDIT_MAX = 8,
  localparam int CW         = credit_w(CREDIT_MAX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  credit_link_arbiter_if.master link,
  input  logic [CW-1:0]         credit_initial,
  input  logic [CW-1:0]         credit_withhold,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_available,
  output logic                  credit_overflow
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  link_state_e       state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_valid_q, push_valid_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              in_reset_q, in_reset_d;

  logic              grant_en;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     ptr_next;
  logic [CW:0]       credit_sum;

  assign credit_available = (count_q > credit_withhold);

  // A receiver reset arriving in ACTIVE kills any grant in that same cycle.
  assign grant_en = (state_q == ACTIVE) && !link.push_receiver_in_reset && credit_available;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i      (link.req_valid),
    .en_i       (grant_en),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .gnt_any_o  (gnt_any),
    .gnt_idx_o  (gnt_idx),
    .ptr_next_o (ptr_next)
  );

  assign link.req_ready            = gnt;
  assign link.push_valid           = push_valid_q;
  assign link.push_data            = push_data_q;
  assign link.push_sender_in_reset = in_reset_q;
  assign link.push_credit_stall    = in_reset_q;
  assign credit_count              = count_q;
  assign credit_overflow           = ovf_q;

  // Next-state, credit accounting and link register inputs.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    ovf_d        = ovf_q;
    ptr_d        = ptr_q;
    credit_sum   = '0;
    case (state_q)
      RESET: begin
        state_d = SYNC;
      end
      SYNC: begin
        if (!link.push_receiver_in_reset) begin
          state_d = ACTIVE;
          count_d = (credit_initial > CW'(CREDIT_MAX)) ? CW'(CREDIT_MAX) : credit_initial;
        end else begin
          state_d = SYNC;
        end
      end
      ACTIVE: begin
        if (link.push_receiver_in_reset) begin
          state_d = SYNC;
          count_d = '0;
        end else begin
          // Grant only happens with count above withhold, so this cannot underflow.
          credit_sum = {1'b0, count_q} + {{CW{1'b0}}, link.push_credit}
                     - {{CW{1'b0}}, gnt_any};
          if (credit_sum > (CW+1)'(CREDIT_MAX)) begin
            count_d = CW'(CREDIT_MAX);
            ovf_d   = 1'b1;
          end else begin
            count_d = credit_sum[CW-1:0];
          end
          push_valid_d = gnt_any;
          if (gnt_any) begin
            push_data_d = link.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            ptr_d       = ptr_next;
          end else begin
            ptr_d       = ptr_q;
          end
        end
      end
      default: begin
        state_d = RESET;
        count_d = '0;
      end
    endcase
    in_reset_d = (state_d != ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET;
      count_q      <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      ovf_q        <= 1'b0;
      ptr_q        <= '0;
      in_reset_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      ovf_q        <= ovf_d;
      ptr_q        <= ptr_d;
      in_reset_q   <= in_reset_d;
    end
  end

endmodule
